rf_wr_arbiter: RTL

- Shares the register file's single write port between two writeback requesters: req0 (ALU writeback) and req1 (load/MEM writeback).
- Valid/ready handshake on each requester; round-robin arbitration; registered drive of the regfile write port (Regwrite/wa/wd).
- Sits between the writeback sources and regfile; optionally forwards the in-flight write onto both regfile read ports.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rr_arb2.sv | 34 +++
 rtl/rf_wr_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and the writeback request record used by the
// write-port arbiter and its clients.
package rf_pkg;

   localparam int unsigned RF_DATA_W   = 32;
   localparam int unsigned RF_ADDR_W   = 5;
   localparam int unsigned RF_ZERO_REG = 0;

   typedef struct packed {
      logic                 valid;
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } rf_wr_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a last-grant flop; on a tie the requester that
// did not win last time is granted. Reset leaves last grant at 1 so req[0] wins first.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   logic last_q;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // A grant is only issued to an active request, so any grant is a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (|gnt) begin
         last_q <= gnt[1];
      end
   end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Shares the regfile write port between ALU (req0) and load (req1) writeback.
// Define RF_BYPASS_EN to forward the in-flight write onto both read ports.
module rf_wr_arbiter
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_i,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [ADDR_W-1:0] req0_addr_i,
   input  logic [DATA_W-1:0] req0_data_i,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [ADDR_W-1:0] req1_addr_i,
   input  logic [DATA_W-1:0] req1_data_i,
   output logic              Regwrite_o,
   output logic [ADDR_W-1:0] wa_o,
   output logic [DATA_W-1:0] wd_o,
   input  logic [ADDR_W-1:0] ra0_i,
   input  logic [ADDR_W-1:0] ra1_i,
   input  logic [DATA_W-1:0] rf_rd0_i,
   input  logic [DATA_W-1:0] rf_rd1_i,
   output logic [DATA_W-1:0] rd0_o,
   output logic [DATA_W-1:0] rd1_o,
   output logic [CNT_W-1:0]  conflict_cnt_o
);

   localparam logic [ADDR_W-1:0] ZeroReg = ADDR_W'(RF_ZERO_REG);

   logic [1:0]        gnt;
   logic              arb_en;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;
   logic              regwrite_q;
   logic [ADDR_W-1:0] wa_q;
   logic [DATA_W-1:0] wd_q;
   logic [CNT_W-1:0]  cnt_q;

   // Gating with rst_n keeps both readies low for the whole reset pulse.
   assign arb_en = rst_n & ~stall_i;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({req1_valid_i, req0_valid_i}),
      .en    (arb_en),
      .gnt   (gnt)
   );

   assign req0_ready_o = gnt[0];
   assign req1_ready_o = gnt[1];

   always_comb begin
      win_addr = gnt[1] ? req1_addr_i : req0_addr_i;
      win_data = gnt[1] ? req1_data_i : req0_data_i;
   end

   // r0 writes are consumed but never drive the write enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regwrite_q <= 1'b0;
         wa_q       <= '0;
         wd_q       <= '0;
      end else if (|gnt) begin
         regwrite_q <= (win_addr != ZeroReg);
         wa_q       <= win_addr;
         wd_q       <= win_data;
      end else begin
         regwrite_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (req0_valid_i && req1_valid_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign Regwrite_o     = regwrite_q;
   assign wa_o           = wa_q;
   assign wd_o           = wd_q;
   assign conflict_cnt_o = cnt_q;

`ifdef RF_BYPASS_EN
   always_comb begin
      rd0_o = (regwrite_q && (wa_q == ra0_i) && (ra0_i != ZeroReg)) ? wd_q : rf_rd0_i;
      rd1_o = (regwrite_q && (wa_q == ra1_i) && (ra1_i != ZeroReg)) ? wd_q : rf_rd1_i;
   end
`else
   assign rd0_o = rf_rd0_i;
   assign rd1_o = rf_rd1_i;
`endif

endmodule
